// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains the EDC word FIFO through a one-cycle-latency read port and presents
// the words on a valid/ready stream. A two-entry output buffer (head/tail)
// absorbs the read latency so a continuously ready consumer sees one word per
// cycle. Also provides a synchronous flush and a wrapping delivered-word count.

module fifo_stream_reader #(
  parameter int P_DATA_W = 11,
  parameter int P_CNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [P_DATA_W-1:0] i_fifo_data,
  input  logic                i_fifo_empty,
  output logic                o_fifo_read,
  input  logic                i_flush,
  output logic                o_valid,
  output logic [P_DATA_W-1:0] o_data,
  input  logic                i_ready,
  output logic [P_CNT_W-1:0]  o_count,
  output logic                o_busy
);

  logic [1:0]          occ_q;
  logic                inflight_q;
  logic [P_DATA_W-1:0] head_q;
  logic [P_DATA_W-1:0] tail_q;
  logic [P_CNT_W-1:0]  count_q;

  logic                xfer;
  logic [1:0]          occ_free;
  logic [1:0]          occ_after_xfer;

  // Transfer detect and pop decision; a pop is only issued when the slot it
  // will land in is guaranteed free after accounting for the word in flight.
  always_comb begin
    xfer           = (occ_q != 2'd0) && i_ready && !i_flush;
    occ_free       = 2'd2 - occ_q + {1'b0, xfer};
    occ_after_xfer = occ_q - {1'b0, xfer};
    o_fifo_read    = !i_fifo_empty && !i_flush && !i_reset &&
                     (occ_free > {1'b0, inflight_q});
  end

  // Buffer, in-flight tracking and delivered-word counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (i_flush) begin
      // The word returning from last cycle's pop is dropped with the buffer.
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_fifo_read;
      if (xfer) begin
        count_q <= count_q + P_CNT_W'(1);
        head_q  <= tail_q;
      end
      // Capture lands in whichever slot is first free after this cycle's
      // transfer; this assignment overrides the head shift when both apply.
      if (inflight_q) begin
        if (occ_after_xfer == 2'd0) begin
          head_q <= i_fifo_data;
        end else begin
          tail_q <= i_fifo_data;
        end
      end
      occ_q <= occ_after_xfer + {1'b0, inflight_q};
    end
  end

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = head_q;
  assign o_count = count_q;
  assign o_busy  = (occ_q != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Drives fifo_stream_reader from a queue-based FIFO with one-cycle read
// latency and checks every cycle against a queue-level behavioural model,
// followed by directed scenarios with hand-computed expectations.

module tb_fifo_stream_reader;
  localparam int DW = 11;
  localparam int CW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_read;
  logic          i_flush;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  fifo_stream_reader #(.P_DATA_W(DW), .P_CNT_W(CW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_read  (o_fifo_read),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_busy       (o_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // FIFO environment
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend;
  bit            pend_v = 1'b0;

  // behavioural model
  logic [DW-1:0] m_buf[$];
  bit            m_inflight = 1'b0;
  bit            m_known    = 1'b0;
  bit            m_zero     = 1'b0;
  logic [CW-1:0] m_count    = '0;

  // per-cycle observation logs
  bit            pop_log[$];
  bit            valid_log[$];
  bit            busy_log[$];
  logic [DW-1:0] data_log[$];
  logic [CW-1:0] count_log[$];
  logic [DW-1:0] delivered[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    pop_log.delete();
    valid_log.delete();
    busy_log.delete();
    data_log.delete();
    count_log.delete();
    delivered.delete();
  endtask

  // Compare DUT against the model for this cycle, then advance the model.
  task automatic model_step();
    bit exp_valid, xfer, exp_read;
    exp_valid = (m_buf.size() != 0);
    xfer      = exp_valid && i_ready && !i_flush && !i_reset;
    exp_read  = !i_fifo_empty && !i_flush && !i_reset &&
                ((2 - int'(m_buf.size()) + int'(xfer)) > int'(m_inflight));
    if (m_known) begin
      chk("fifo_read", 32'(o_fifo_read), 32'(exp_read));
      chk("valid", 32'(o_valid), 32'(exp_valid));
      if (exp_valid) chk("data", 32'(o_data), 32'(m_buf[0]));
      else if (m_zero) chk("data_rst", 32'(o_data), 32'h0);
      chk("busy", 32'(o_busy), 32'(exp_valid || m_inflight));
      chk("count", 32'(o_count), 32'(m_count));
    end
    pop_log.push_back(o_fifo_read);
    valid_log.push_back(o_valid);
    busy_log.push_back(o_busy);
    data_log.push_back(o_data);
    count_log.push_back(o_count);
    if (o_valid && i_ready && !i_flush && !i_reset) delivered.push_back(o_data);
    pend_v = o_fifo_read && (fifo_q.size() > 0);
    if (pend_v) pend = fifo_q.pop_front();
    if (i_reset) begin
      m_buf.delete();
      m_inflight = 1'b0;
      m_count    = '0;
      m_known    = 1'b1;
      m_zero     = 1'b1;
    end else if (i_flush) begin
      m_buf.delete();
      m_inflight = 1'b0;
      m_zero     = 1'b0;
    end else begin
      if (xfer) begin
        void'(m_buf.pop_front());
        m_count = m_count + 1'b1;
      end
      if (m_inflight) begin
        m_buf.push_back(i_fifo_data);
        m_zero = 1'b0;
      end
      m_inflight = exp_read;
    end
  endtask

  // One clock cycle: entered just after a rising edge.
  task automatic cyc(input bit rdy, input bit fl, input bit rst, input bit stall);
    i_ready      = rdy;
    i_flush      = fl;
    i_reset      = rst;
    i_fifo_empty = (fifo_q.size() == 0) || stall;
    i_fifo_data  = pend_v ? pend : DW'($urandom);
    @(negedge i_clk);
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_cycle();
    fifo_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int s;
    i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    i_fifo_empty = 1'b1; i_fifo_data = '0;
    reset_cycle();
    reset_cycle();

    // 1: five words, ready held high
    for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
    clear_logs();
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_rst_valid", 32'(valid_log[0]), 32'h0);
    chk("t1_rst_data",  32'(data_log[0]),  32'h0);
    chk("t1_rst_count", 32'(count_log[0]), 32'h0);
    chk("t1_rst_busy",  32'(busy_log[0]),  32'h0);
    for (int i = 0; i < 6; i++) chk("t1_pop", 32'(pop_log[i]), (i < 5) ? 32'h1 : 32'h0);
    chk("t1_valid_c1", 32'(valid_log[1]), 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid_seq", 32'(valid_log[2+i]), 32'h1);
      chk("t1_data_seq",  32'(data_log[2+i]),  32'(i + 1));
    end
    chk("t1_ndeliv", 32'(delivered.size()), 32'd5);
    chk("t1_count", 32'(o_count), 32'd5);
    chk("t1_busy_c6", 32'(busy_log[6]), 32'h1);
    chk("t1_busy_c7", 32'(busy_log[7]), 32'h0);

    // 2: backpressure then resume
    reset_cycle();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(12'h0A0 + i));
    clear_logs();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b0, 1'b0, 1'b0);
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(pop_log[i]);
    chk("t2_pops_stalled", 32'(s), 32'd2);
    for (int i = 2; i < 10; i++) chk("t2_hold", 32'(data_log[i]), 32'h0A1);
    s = 0;
    for (int i = 10; i < 18; i++) s += int'(pop_log[i]);
    chk("t2_pops_resume", 32'(s), 32'd2);
    for (int i = 10; i < 14; i++) chk("t2_no_gap", 32'(valid_log[i]), 32'h1);
    chk("t2_ndeliv", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      chk("t2_order", 32'(delivered[i]), 32'(12'h0A1 + i));
    chk("t2_count", 32'(o_count), 32'd4);

    // 3: toggling ready
    reset_cycle();
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(12'h0B0 + i));
    clear_logs();
    for (int i = 0; i < 40; i++) cyc(((i % 2) == 0), 1'b0, 1'b0, 1'b0);
    chk("t3_ndeliv", 32'(delivered.size()), 32'd8);
    for (int i = 0; i < 8 && i < delivered.size(); i++)
      chk("t3_order", 32'(delivered[i]), 32'(12'h0B0 + i));
    chk("t3_count", 32'(o_count), 32'd8);

    // 4: flush the cycle after a pop
    reset_cycle();
    for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(12'h0C0 + i));
    clear_logs();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_pop_c0", 32'(pop_log[0]), 32'h1);
    chk("t4_pop_flush", 32'(pop_log[1]), 32'h0);
    chk("t4_pop_c2", 32'(pop_log[2]), 32'h1);
    chk("t4_valid_c2", 32'(valid_log[2]), 32'h0);
    chk("t4_count_c2", 32'(count_log[2]), 32'h0);
    chk("t4_ndeliv", 32'(delivered.size()), 32'd2);
    if (delivered.size() == 2) begin
      chk("t4_word0", 32'(delivered[0]), 32'h0C2);
      chk("t4_word1", 32'(delivered[1]), 32'h0C3);
    end
    chk("t4_count", 32'(o_count), 32'd2);

    // 5: reset mid-stream
    reset_cycle();
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(12'h0D0 + i));
    clear_logs();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_valid", 32'(valid_log[6]), 32'h0);
    chk("t5_data",  32'(data_log[6]),  32'h0);
    chk("t5_count", 32'(count_log[6]), 32'h0);
    chk("t5_busy",  32'(busy_log[6]),  32'h0);
    chk("t5_ndeliv", 32'(delivered.size()), 32'd8);
    if (delivered.size() == 8) begin
      for (int i = 0; i < 3; i++) chk("t5_pre", 32'(delivered[i]), 32'(12'h0D0 + i));
      for (int i = 3; i < 8; i++) chk("t5_post", 32'(delivered[i]), 32'(12'h0D2 + i));
    end
    chk("t5_count_end", 32'(o_count), 32'd5);

    // 6: counter wrap
    reset_cycle();
    fifo_q.push_back(DW'(12'h0E1));
    clear_logs();
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    release dut.count_q;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre", 32'(count_log[1]), 32'hFFFF);
    chk("t6_wrap", 32'(count_log[3]), 32'h0);
    chk("t6_ndeliv", 32'(delivered.size()), 32'd1);

    // random traffic with flush, reset, FIFO stalls and backpressure
    reset_cycle();
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 12) fifo_q.push_back(DW'($urandom));
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0));
    end
    chk("rand_activity", 32'(delivered.size() > 500), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
